// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - two-stage multiply-accumulate pipeline with frame accumulation
//
// Purpose:
//   Stage 1 registers the full a*b product, the addend c and the mode.
//   Stage 2 either returns a*b+c directly (mode 0) or accumulates ACC_LEN
//   products into one frame result (mode 1). Output is a valid/ready slot.
//
// Ports:
//   clc        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   operand set a/b/c/mode is valid
//   in_ready   block accepts an operand set this cycle
//   a, b       SIZE-bit unsigned operands
//   c          OUTSIZE-bit addend (used on mode-0 sets and the first set of a frame)
//   mode       0 = single a*b+c, 1 = accumulate frame
//   out_valid  data_out holds a result
//   out_ready  downstream consumes the result
//   data_out   OUTSIZE-bit result
//   ovf        result overflowed OUTSIZE (valid with out_valid)
//
// Configuration:
//   MAC_PIPE_SAT_EN  defined: saturate to all-ones and flag ovf on overflow;
//                    undefined: wrap modulo 2^OUTSIZE, ovf tied to 0.

module mac_pipe #(
    parameter int SIZE    = 8,
    parameter int OUTSIZE = 16,
    parameter int ACC_LEN = 4
) (
    input  logic               clc,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIZE-1:0]    a,
    input  logic [SIZE-1:0]    b,
    input  logic [OUTSIZE-1:0] c,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUTSIZE-1:0] data_out,
    output logic               ovf
);

    localparam int PW = 2 * SIZE;
    localparam int SW = OUTSIZE + 1;
    localparam int CW = $clog2(ACC_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // stage 1
    logic               s1_valid_q, s1_valid_d;
    logic [PW-1:0]      s1_prod_q,  s1_prod_d;
    logic [OUTSIZE-1:0] s1_c_q,     s1_c_d;
    logic               s1_mode_q,  s1_mode_d;

    // frame state
    state_t             state_q,    state_d;
    logic [OUTSIZE-1:0] acc_q,      acc_d;
    logic               acc_ovf_q,  acc_ovf_d;
    logic [CW-1:0]      cnt_q,      cnt_d;

    // output slot
    logic               out_valid_q, out_valid_d;
    logic [OUTSIZE-1:0] data_out_q,  data_out_d;
    logic               ovf_q,       ovf_d;

    // stage-2 arithmetic
    logic [OUTSIZE-1:0] addend;
    logic [SW-1:0]      sum_w;
    logic [OUTSIZE-1:0] sum_val;
    logic               sum_ovf;
    logic               frame_ovf;

    // Whole pipe stalls only while a result sits unconsumed.
    assign in_ready  = ~(out_valid_q & ~out_ready);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign ovf       = ovf_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s1_c_d     = s1_c_q;
        s1_mode_d  = s1_mode_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_prod_d = PW'(a) * PW'(b);
                s1_c_d    = c;
                s1_mode_d = mode;
            end
        end
    end

    // Inside a frame the running accumulator replaces c as the addend.
    assign addend = (state_q == ACCUM) ? acc_q : s1_c_q;
    assign sum_w  = SW'(s1_prod_q) + SW'(addend);

`ifdef MAC_PIPE_SAT_EN
    assign sum_ovf = sum_w[OUTSIZE];
    assign sum_val = sum_w[OUTSIZE] ? {OUTSIZE{1'b1}} : sum_w[OUTSIZE-1:0];
`else
    logic sum_carry_unused;
    assign sum_carry_unused = sum_w[OUTSIZE];
    assign sum_ovf = 1'b0;
    assign sum_val = sum_w[OUTSIZE-1:0];
`endif

    // Overflow is sticky for the frame; a saturated accumulator stays saturated.
    assign frame_ovf = ((state_q == ACCUM) & acc_ovf_q) | sum_ovf;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q & ~out_ready;
        data_out_d  = data_out_q;
        ovf_d       = ovf_q;
        if (in_ready && s1_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (!s1_mode_q) begin
                        out_valid_d = 1'b1;
                        data_out_d  = sum_val;
                        ovf_d       = sum_ovf;
                    end else begin
                        acc_d     = sum_val;
                        acc_ovf_d = sum_ovf;
                        cnt_d     = CW'(1);
                        state_d   = ACCUM;
                    end
                end
                ACCUM: begin
                    if (cnt_q == CNT_LAST) begin
                        out_valid_d = 1'b1;
                        data_out_d  = sum_val;
                        ovf_d       = frame_ovf;
                        acc_d       = '0;
                        acc_ovf_d   = 1'b0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d     = sum_val;
                        acc_ovf_d = frame_ovf;
                        cnt_d     = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clc or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_c_q      <= '0;
            s1_mode_q   <= 1'b0;
            state_q     <= IDLE;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_c_q      <= s1_c_d;
            s1_mode_q   <= s1_mode_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
